// File: rtl/tone_gen_pkg.sv
// Shared encodings and elaboration-time helpers for the tone generator.
// The quarter-wave helper uses real math and is only ever called with constant arguments.
package tone_gen_pkg;

   typedef enum logic [1:0] {
      MODE_SINE   = 2'b00,
      MODE_SQUARE = 2'b01,
      MODE_ZERO   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam real PI = 3.14159265358979323846;

   function automatic logic [31:0] full_pos(input int data_w);
      return (32'd1 << (data_w - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] full_neg(input int data_w);
      return 32'd1 << (data_w - 1);
   endfunction

   // Entry k of the first quarter wave, rounded half-up; the peak is forced exact.
   function automatic logic [31:0] quarter_entry(input int k, input int steps, input int data_w);
      real amp;
      real v;
      amp = (2.0 ** (data_w - 1)) - 1.0;
      if (4 * k >= steps) begin
         v = amp;
      end else begin
         v = amp * $sin(2.0 * PI * $itor(k) / $itor(steps));
      end
      return 32'($rtoi(v + 0.5));
   endfunction

endpackage

// File: rtl/tone_lut.sv
// Combinational waveform lookup: quarter-wave ROM plus symmetry and sign
// folding, producing the unshifted sample for a phase and mode.
module tone_lut
   import tone_gen_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int STEPS   = 8,
   parameter int PHASE_W = 3
) (
   input  logic [PHASE_W-1:0] phase,
   input  logic [1:0]         mode,
   output logic [DATA_W-1:0]  value
);

   localparam int QTR = STEPS / 4;
   localparam logic [31:0] POS32 = full_pos(DATA_W);
   localparam logic [31:0] NEG32 = full_neg(DATA_W);
   localparam logic [DATA_W-1:0] POS_FS = POS32[DATA_W-1:0];
   localparam logic [DATA_W-1:0] NEG_FS = NEG32[DATA_W-1:0];

   logic [DATA_W-1:0]  rom [0:QTR];
   logic [1:0]         quad_s;
   logic [PHASE_W-1:0] off_s;
   logic [PHASE_W-1:0] idx_s;
   logic [DATA_W-1:0]  mag_s;
   logic [DATA_W-1:0]  sine_s;

   for (genvar i = 0; i <= QTR; i++) begin : g_rom
      localparam logic [31:0] ENTRY = quarter_entry(i, STEPS, DATA_W);
      assign rom[i] = ENTRY[DATA_W-1:0];
   end

   // Fold the phase onto the quarter wave and pick sign per half period.
   always_comb begin
      quad_s = phase[PHASE_W-1 -: 2];
      off_s  = phase & PHASE_W'(QTR - 1);
      if (quad_s[0]) begin
         idx_s = PHASE_W'(QTR) - off_s;
      end else begin
         idx_s = off_s;
      end
      mag_s = {DATA_W{1'b0}};
      for (int i = 0; i <= QTR; i++) begin
         mag_s = (idx_s == PHASE_W'(i)) ? rom[i] : mag_s;
      end
      // The trough uses true negative full scale rather than -(max positive).
      if (phase == PHASE_W'(3 * QTR)) begin
         sine_s = NEG_FS;
      end else if (quad_s[1]) begin
         sine_s = -mag_s;
      end else begin
         sine_s = mag_s;
      end
      case (mode)
         MODE_SINE:   value = sine_s;
         MODE_SQUARE: value = phase[PHASE_W-1] ? NEG_FS : POS_FS;
         default:     value = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/tone_gen.sv
// Tone generator: steps a phase index through a sine/square table, holding
// each sample for a programmable number of cycles, with arithmetic attenuation.
module tone_gen
   import tone_gen_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int STEPS  = 8,
   parameter int HOLD_W = 5
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic [HOLD_W-1:0]          i_hold,
   input  logic [1:0]                 i_mode,
   input  logic [2:0]                 i_shift,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_stb,
   output logic                       o_wrap,
   output logic [$clog2(STEPS)-1:0]   o_phase
);

   localparam int PHASE_W = $clog2(STEPS);

   state_t             state_r;
   logic [HOLD_W-1:0]  cnt_r;
   logic [HOLD_W-1:0]  hold_r;
   logic [PHASE_W-1:0] phase_r;
   logic [DATA_W-1:0]  data_r;
   logic               stb_r;
   logic               wrap_r;

   logic [PHASE_W-1:0] lut_phase_s;
   logic [DATA_W-1:0]  lut_value_s;
   logic [DATA_W-1:0]  shaped_s;
   logic               boundary_s;

   // Phase of the sample issued at the next strobe: 0 on start, else successor.
   always_comb begin
      if (state_r == ST_RUN) begin
         lut_phase_s = phase_r + PHASE_W'(1);
      end else begin
         lut_phase_s = PHASE_W'(0);
      end
      boundary_s = (cnt_r == hold_r);
      shaped_s   = $signed(lut_value_s) >>> i_shift;
   end

   tone_lut #(
      .DATA_W  (DATA_W),
      .STEPS   (STEPS),
      .PHASE_W (PHASE_W)
   ) u_lut (
      .phase (lut_phase_s),
      .mode  (i_mode),
      .value (lut_value_s)
   );

   // Control FSM with registered sample outputs; controls are sampled only when a sample is issued.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {HOLD_W{1'b0}};
         hold_r  <= {HOLD_W{1'b0}};
         phase_r <= {PHASE_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
         stb_r   <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_en) begin
                  state_r <= ST_RUN;
                  cnt_r   <= {HOLD_W{1'b0}};
                  hold_r  <= i_hold;
                  phase_r <= {PHASE_W{1'b0}};
                  data_r  <= shaped_s;
                  stb_r   <= 1'b1;
                  wrap_r  <= 1'b1;
               end else begin
                  cnt_r   <= {HOLD_W{1'b0}};
                  phase_r <= {PHASE_W{1'b0}};
                  data_r  <= {DATA_W{1'b0}};
                  stb_r   <= 1'b0;
                  wrap_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!i_en) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= {HOLD_W{1'b0}};
                  phase_r <= {PHASE_W{1'b0}};
                  data_r  <= {DATA_W{1'b0}};
                  stb_r   <= 1'b0;
                  wrap_r  <= 1'b0;
               end else if (boundary_s) begin
                  cnt_r   <= {HOLD_W{1'b0}};
                  hold_r  <= i_hold;
                  phase_r <= lut_phase_s;
                  data_r  <= shaped_s;
                  stb_r   <= 1'b1;
                  wrap_r  <= (lut_phase_s == PHASE_W'(0));
               end else begin
                  cnt_r   <= cnt_r + HOLD_W'(1);
                  stb_r   <= 1'b0;
                  wrap_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= {HOLD_W{1'b0}};
               phase_r <= {PHASE_W{1'b0}};
               data_r  <= {DATA_W{1'b0}};
               stb_r   <= 1'b0;
               wrap_r  <= 1'b0;
            end
         endcase
      end
   end

   assign o_data  = data_r;
   assign o_stb   = stb_r;
   assign o_wrap  = wrap_r;
   assign o_phase = phase_r;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: expected samples are queued as stimulus is
// applied and checked against each strobe, including hold lengths.
module tb_tone_gen;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  phase;
      logic        wrap;
      int          len;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [4:0]  hold;
   logic [1:0]  mode;
   logic [2:0]  shift;
   logic [15:0] data;
   logic        stb;
   logic        wrap;
   logic [2:0]  phase;

   logic [15:0] sine_tbl [0:7] = '{16'h0000, 16'h5A82, 16'h7FFF, 16'h5A82,
                                   16'h0000, 16'hA57E, 16'h8000, 16'hA57E};

   exp_t        sb [$];
   int          n_tests = 0;
   int          n_fail = 0;
   bit          have_prev = 1'b0;
   int          prev_len = 0;
   int          cyc_since = 0;
   logic [15:0] last_data = 16'h0000;
   logic [2:0]  last_phase = 3'd0;

   always #5 clk = ~clk;

   tone_gen dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (en),
      .i_hold  (hold),
      .i_mode  (mode),
      .i_shift (shift),
      .o_data  (data),
      .o_stb   (stb),
      .o_wrap  (wrap),
      .o_phase (phase)
   );

   function automatic logic [15:0] model(input logic [1:0] m, input int k, input int sh);
      logic signed [15:0] base;
      case (m)
         2'b00:   base = sine_tbl[k];
         2'b01:   base = (k < 4) ? 16'sh7FFF : 16'sh8000;
         default: base = 16'sh0000;
      endcase
      return base >>> sh;
   endfunction

   task automatic push_run(input logic [1:0] m, input int sh, input int start, input int n, input int len);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.phase = 3'((start + i) % 8);
         e.data  = model(m, int'(e.phase), sh);
         e.wrap  = (e.phase == 3'd0);
         e.len   = len;
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc_since++;
      if (stb === 1'b1) begin
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL stray_strobe: got data=%h phase=%0d, want no strobe", data, phase);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            assert ({data, phase, wrap} === {e.data, e.phase, e.wrap}) else begin
               n_fail++;
               $error("FAIL sample: got data=%h phase=%0d wrap=%b, want data=%h phase=%0d wrap=%b",
                      data, phase, wrap, e.data, e.phase, e.wrap);
            end
            if (have_prev) begin
               n_tests++;
               assert (cyc_since == prev_len) else begin
                  n_fail++;
                  $error("FAIL hold_len: got %0d cycles before phase %0d, want %0d", cyc_since, e.phase, prev_len);
               end
            end
            have_prev  = 1'b1;
            prev_len   = e.len;
            last_data  = e.data;
            last_phase = e.phase;
         end
         cyc_since = 0;
      end else if (have_prev) begin
         n_tests++;
         assert ({data, phase, wrap} === {last_data, last_phase, 1'b0}) else begin
            n_fail++;
            $error("FAIL held_sample: got data=%h phase=%0d wrap=%b, want data=%h phase=%0d wrap=0",
                   data, phase, wrap, last_data, last_phase);
         end
      end
   endtask

   task automatic run_until_empty(input int budget, input string tag);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL %s_timeout: got %0d samples outstanding, want 0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic idle_check(input string tag);
      n_tests++;
      assert ({data, stb, wrap, phase} === 21'd0) else begin
         n_fail++;
         $error("FAIL %s: got data=%h stb=%b wrap=%b phase=%0d, want all zero", tag, data, stb, wrap, phase);
      end
   endtask

   task automatic go_idle(input string tag);
      en = 1'b0;
      have_prev = 1'b0;
      tick();
      idle_check(tag);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; hold = 5'd16; mode = 2'b00; shift = 3'd0;
      repeat (3) tick();
      idle_check("reset_state");
      rst = 1'b0;
      tick();
      idle_check("idle_en_low");

      // Default sine, 17-cycle hold, one full period plus the wrap.
      en = 1'b1;
      push_run(2'b00, 0, 0, 9, 17);
      run_until_empty(200, "sine_hold16");

      // Per-cycle sine at half amplitude.
      go_idle("idle_before_fast");
      hold = 5'd0; shift = 3'd1; en = 1'b1;
      push_run(2'b00, 1, 0, 9, 1);
      run_until_empty(20, "sine_fast_shift1");

      // Square wave, 4-cycle hold.
      go_idle("idle_before_square");
      mode = 2'b01; hold = 5'd3; shift = 3'd0; en = 1'b1;
      push_run(2'b01, 0, 0, 9, 4);
      run_until_empty(50, "square_hold3");

      // Square at maximum attenuation.
      go_idle("idle_before_sq_shift7");
      hold = 5'd0; shift = 3'd7; en = 1'b1;
      push_run(2'b01, 7, 0, 9, 1);
      run_until_empty(20, "square_shift7");

      // Reserved mode outputs zero while phase keeps running.
      go_idle("idle_before_rsvd");
      mode = 2'b11; shift = 3'd0; en = 1'b1;
      push_run(2'b11, 0, 0, 9, 1);
      run_until_empty(20, "reserved_mode");

      // Hold and shift changed mid-sample at phase 2 apply from phase 3.
      go_idle("idle_before_midchange");
      mode = 2'b00; hold = 5'd16; shift = 3'd0; en = 1'b1;
      push_run(2'b00, 0, 0, 3, 17);
      run_until_empty(80, "midchange_pre");
      repeat (5) tick();
      hold = 5'd2; shift = 3'd2;
      push_run(2'b00, 2, 3, 6, 3);
      run_until_empty(60, "midchange_post");

      // Reset mid-sample at phase 5, restart, then drop enable on a boundary.
      go_idle("idle_before_reset_test");
      hold = 5'd1; shift = 3'd0; en = 1'b1;
      push_run(2'b00, 0, 0, 6, 2);
      run_until_empty(30, "pre_reset");
      rst = 1'b1;
      have_prev = 1'b0;
      tick();
      idle_check("reset_mid_sample");
      rst = 1'b0;
      push_run(2'b00, 0, 0, 3, 2);
      run_until_empty(20, "restart_after_reset");
      tick();
      go_idle("en_low_on_boundary");
      tick();
      idle_check("idle_stays_quiet");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
